// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl
//   Single-port unified main memory with two request channels: instruction
//   fetch (i_*) and data load/store (d_*). One access is in flight at a time.
//   Each access sees WAIT wait states, then a one-cycle ready pulse. When both
//   channels request at once, the channel that was not served last wins.
//
//   Ports
//     clk, reset                 clock, synchronous active-high reset
//     i_req, i_addr              fetch request / byte address
//     i_rdata, i_ready           fetched word (0 unless i_ready), completion pulse
//     d_req, d_we, d_addr        data request, 1=store, byte address
//     d_wdata                    store data
//     d_rdata, d_ready           load word (0 unless d_ready), completion pulse
//     err                        pulses with ready on a misaligned/out-of-range access
//     mon_we, mon_addr,          committed-store observation port, present only
//     mon_wdata                  when UMEM_WRITE_MONITOR_EN is defined
//
//   Parameters: n (word width, default `WORDSIZE = 32), ADDR_W (word-index
//   width), WAIT (wait states, 0..15).
//
//   State | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no access in flight; arbitrate and accept a request
//   WAIT  | counting down wait states for the latched access
//   RESP  | ready/rdata/err presented for exactly one cycle

`ifndef WORDSIZE
`define WORDSIZE 32
`endif

module unified_mem_ctrl #(
    parameter int n      = `WORDSIZE,
    parameter int ADDR_W = 8,
    parameter int WAIT   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_req,
    input  logic [n-1:0] i_addr,
    output logic [n-1:0] i_rdata,
    output logic         i_ready,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [n-1:0] d_addr,
    input  logic [n-1:0] d_wdata,
    output logic [n-1:0] d_rdata,
    output logic         d_ready,
    output logic         err
`ifdef UMEM_WRITE_MONITOR_EN
    ,
    output logic         mon_we,
    output logic [n-1:0] mon_addr,
    output logic [n-1:0] mon_wdata
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t              state;
    logic [3:0]          cnt;
    logic                last_d;      // 1 = data channel was served last
    logic                lat_d;
    logic                lat_we;
    logic [n-1:0]        lat_addr;
    logic [n-1:0]        lat_wdata;

    logic [n-1:0]        mem [0:(1<<ADDR_W)-1];

    logic                grant_d;
    logic                cur_d;
    logic                cur_we;
    logic [n-1:0]        cur_addr;
    logic [n-1:0]        cur_wdata;
    logic [ADDR_W-1:0]   cur_idx;
    logic                cur_err;
    logic                go_resp;
    logic                mem_we;

    // In IDLE the access being decided is the one on the ports; afterwards it
    // is the latched one. This lets the WAIT=0 build go straight to RESP.
    always_comb begin
        grant_d = d_req && (!i_req || !last_d);
        if (state == S_IDLE) begin
            cur_d     = grant_d;
            cur_we    = grant_d && d_we;
            cur_addr  = grant_d ? d_addr : i_addr;
            cur_wdata = d_wdata;
        end else begin
            cur_d     = lat_d;
            cur_we    = lat_we;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
        end
        cur_idx = cur_addr[ADDR_W+1:2];
        cur_err = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (ADDR_W + 2)) != '0);
    end

    always_comb begin
        go_resp = 1'b0;
        case (state)
            S_IDLE:  go_resp = (i_req || d_req) && (WAIT == 0);
            S_WAIT:  go_resp = (cnt == 4'd1);
            default: go_resp = 1'b0;
        endcase
    end

    // Stores commit on the edge that enters RESP; erroneous stores and any
    // access cut short by reset never reach the array.
    assign mem_we = go_resp && cur_we && !cur_err;

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            last_d    <= 1'b0;
            lat_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            err       <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
`ifdef UMEM_WRITE_MONITOR_EN
            mon_we    <= 1'b0;
            mon_addr  <= '0;
            mon_wdata <= '0;
`endif
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            err     <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
`ifdef UMEM_WRITE_MONITOR_EN
            mon_we    <= 1'b0;
            mon_addr  <= '0;
            mon_wdata <= '0;
`endif
            if (go_resp) begin
                i_ready <= !cur_d;
                d_ready <= cur_d;
                err     <= cur_err;
                if (!cur_err && !cur_we) begin
                    if (cur_d) d_rdata <= mem[cur_idx];
                    else       i_rdata <= mem[cur_idx];
                end
`ifdef UMEM_WRITE_MONITOR_EN
                if (mem_we) begin
                    mon_we    <= 1'b1;
                    mon_addr  <= cur_addr;
                    mon_wdata <= cur_wdata;
                end
`endif
            end

            case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        lat_d     <= grant_d;
                        lat_we    <= cur_we;
                        lat_addr  <= cur_addr;
                        lat_wdata <= d_wdata;
                        last_d    <= grant_d;
                        if (go_resp) begin
                            state <= S_RESP;
                            cnt   <= 4'd0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_CNT;
                        end
                    end
                end
                S_WAIT: begin
                    if (go_resp) begin
                        state <= S_RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Bench for unified_mem_ctrl: a WAIT=2 instance (dut) and a WAIT=0 instance
// (dut0) share clock and reset. A word-array model tracks memory contents;
// latency, arbitration order and error classification are computed from the
// access rules directly.
module tb_unified_mem_ctrl;

    localparam int WAIT_A = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ready, d_ready, err;

    logic        i_req0 = 1'b0, d_req0 = 1'b0, d_we0 = 1'b0;
    logic [31:0] i_addr0 = '0, d_addr0 = '0, d_wdata0 = '0;
    logic [31:0] i_rdata0, d_rdata0;
    logic        i_ready0, d_ready0, err0;

`ifdef UMEM_WRITE_MONITOR_EN
    logic        mon_we, mon_we0;
    logic [31:0] mon_addr, mon_wdata, mon_addr0, mon_wdata0;
    int          mon_cnt = 0;
    logic [31:0] mon_last_addr = '0, mon_last_data = '0;
    always @(negedge clk) begin
        if (mon_we === 1'b1) begin
            mon_cnt++;
            mon_last_addr = mon_addr;
            mon_last_data = mon_wdata;
        end
    end
`endif

    unified_mem_ctrl #(.n(32), .ADDR_W(8), .WAIT(WAIT_A)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .err(err)
`ifdef UMEM_WRITE_MONITOR_EN
        , .mon_we(mon_we), .mon_addr(mon_addr), .mon_wdata(mon_wdata)
`endif
    );

    unified_mem_ctrl #(.n(32), .ADDR_W(8), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .i_req(i_req0), .i_addr(i_addr0), .i_rdata(i_rdata0), .i_ready(i_ready0),
        .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
        .d_rdata(d_rdata0), .d_ready(d_ready0), .err(err0)
`ifdef UMEM_WRITE_MONITOR_EN
        , .mon_we(mon_we0), .mon_addr(mon_addr0), .mon_wdata(mon_wdata0)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model  [256];
    bit          valid  [256];
    logic [31:0] model0 [256];

    function automatic bit exp_err(input logic [31:0] a);
        return ((a % 4) != 0) || (a >= 32'd1024);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; i_req0 = 1'b0; d_req0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One access on dut. lat = edges from request to ready (-1 on timeout);
    // rdy_after/rd_after are the ready and rdata seen one cycle later.
    task automatic acc(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic e, output int lat,
                       output logic rdy_after, output logic [31:0] rd_after);
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        lat = -1; rd = 'x; e = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if ((is_d ? d_ready : i_ready) === 1'b1) begin
                lat = k;
                rd  = is_d ? d_rdata : i_rdata;
                e   = err;
                break;
            end
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        rdy_after = is_d ? d_ready : i_ready;
        rd_after  = is_d ? d_rdata : i_rdata;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL reset_i_ready: got %b expected 0", i_ready); end
        n_checks++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL reset_d_ready: got %b expected 0", d_ready); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (i_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_i_rdata: got %h expected 0", i_rdata); end
        n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_d_rdata: got %h expected 0", d_rdata); end
        n_checks++; if ({i_ready0, d_ready0, err0} !== 3'b000) begin n_fail++; $display("FAIL reset_dut0_flags: got %b expected 000", {i_ready0, d_ready0, err0}); end
`ifdef UMEM_WRITE_MONITOR_EN
        n_checks++; if ({mon_we, mon_addr, mon_wdata} !== 65'h0) begin n_fail++; $display("FAIL reset_mon: got %b/%h/%h expected 0", mon_we, mon_addr, mon_wdata); end
`endif
    endtask

    task automatic test_fetch();
        logic [31:0] rd, rda; logic e, ra; int lat;
        acc(1'b1, 1'b1, 32'h08, 32'h1234ABCD, rd, e, lat, ra, rda);
        model[2] = 32'h1234ABCD; valid[2] = 1'b1;
        n_checks++; if (lat !== WAIT_A + 1) begin n_fail++; $display("FAIL preload_lat: got %0d expected %0d", lat, WAIT_A + 1); end
        acc(1'b0, 1'b0, 32'h08, 32'h0, rd, e, lat, ra, rda);
        n_checks++; if (lat !== WAIT_A + 1) begin n_fail++; $display("FAIL fetch_lat: got %0d expected %0d", lat, WAIT_A + 1); end
        n_checks++; if (rd !== model[2]) begin n_fail++; $display("FAIL fetch_data: got %h expected %h", rd, model[2]); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL fetch_err: got %b expected 0", e); end
        n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL fetch_ready_pulse: got %b expected 0", ra); end
        n_checks++; if (rda !== 32'h0) begin n_fail++; $display("FAIL fetch_rdata_idle: got %h expected 0", rda); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, rda; logic e, ra; int lat;
`ifdef UMEM_WRITE_MONITOR_EN
        int mc = mon_cnt;
`endif
        acc(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat, ra, rda);
        model[4] = 32'hDEADBEEF; valid[4] = 1'b1;
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b expected 0", e); end
        n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL store_ready_pulse: got %b expected 0", ra); end
`ifdef UMEM_WRITE_MONITOR_EN
        n_checks++; if (mon_cnt !== mc + 1) begin n_fail++; $display("FAIL mon_pulses: got %0d expected %0d", mon_cnt - mc, 1); end
        n_checks++; if (mon_last_addr !== 32'h10 || mon_last_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mon_payload: got %h/%h expected 00000010/deadbeef", mon_last_addr, mon_last_data); end
`endif
        acc(1'b1, 1'b0, 32'h10, 32'h0, rd, e, lat, ra, rda);
        n_checks++; if (rd !== model[4]) begin n_fail++; $display("FAIL load_data: got %h expected %h", rd, model[4]); end
        n_checks++; if (lat !== WAIT_A + 1) begin n_fail++; $display("FAIL load_lat: got %0d expected %0d", lat, WAIT_A + 1); end
        n_checks++; if (rda !== 32'h0) begin n_fail++; $display("FAIL load_rdata_idle: got %h expected 0", rda); end
    endtask

    task automatic test_arbitration();
        int d_edges[$];
        int i_edges[$];
        logic [31:0] d_vals[$];
        logic [31:0] i_vals[$];
        bit both = 1'b0;
        int per = WAIT_A + 2;
        do_reset();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h08;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        for (int k = 1; k <= 4 * per; k++) begin
            @(posedge clk); #1;
            if (d_ready === 1'b1) begin d_edges.push_back(k); d_vals.push_back(d_rdata); end
            if (i_ready === 1'b1) begin i_edges.push_back(k); i_vals.push_back(i_rdata); end
            if (d_ready === 1'b1 && i_ready === 1'b1) both = 1'b1;
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        // grants alternate D,I,D,I; access j completes j*per + WAIT+1 edges in
        n_checks++; if (both !== 1'b0) begin n_fail++; $display("FAIL arb_overlap: got both-ready %b expected 0", both); end
        n_checks++;
        if (d_edges.size() != 2 || d_edges[0] != WAIT_A + 1 || d_edges[1] != 2 * per + WAIT_A + 1) begin
            n_fail++; $display("FAIL arb_data_order: got %0d grants first at %0d expected 2 at %0d,%0d",
                               d_edges.size(), (d_edges.size() > 0) ? d_edges[0] : -1, WAIT_A + 1, 2 * per + WAIT_A + 1);
        end
        n_checks++;
        if (i_edges.size() != 2 || i_edges[0] != per + WAIT_A + 1 || i_edges[1] != 3 * per + WAIT_A + 1) begin
            n_fail++; $display("FAIL arb_instr_order: got %0d grants first at %0d expected 2 at %0d,%0d",
                               i_edges.size(), (i_edges.size() > 0) ? i_edges[0] : -1, per + WAIT_A + 1, 3 * per + WAIT_A + 1);
        end
        n_checks++;
        if (d_vals.size() < 1 || d_vals[0] !== model[4] || i_vals.size() < 1 || i_vals[0] !== model[2]) begin
            n_fail++; $display("FAIL arb_data: got d=%h i=%h expected d=%h i=%h",
                               (d_vals.size() > 0) ? d_vals[0] : 32'hx, (i_vals.size() > 0) ? i_vals[0] : 32'hx, model[4], model[2]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, rda; logic e, ra; int lat;
        logic [31:0] addrs[3];
        logic [31:0] a;
`ifdef UMEM_WRITE_MONITOR_EN
        int mc = mon_cnt;
`endif
        addrs[0] = 32'h12; addrs[1] = 32'h400; addrs[2] = 32'h11;
        for (int j = 0; j < 2; j++) begin
            a = addrs[j];
            acc(1'b1, 1'b1, a, 32'hBAD0_0000 + j, rd, e, lat, ra, rda);
            n_checks++; if (e !== exp_err(a)) begin n_fail++; $display("FAIL err_store_flag: addr %h got %b expected %b", a, e, exp_err(a)); end
            n_checks++; if (lat !== WAIT_A + 1) begin n_fail++; $display("FAIL err_store_lat: addr %h got %0d expected %0d", a, lat, WAIT_A + 1); end
            n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_store_rdata: addr %h got %h expected 0", a, rd); end
        end
        a = addrs[2];
        acc(1'b1, 1'b0, a, 32'h0, rd, e, lat, ra, rda);
        n_checks++; if (e !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_load: got err=%b rdata=%h expected 1/0", e, rd); end
        n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL err_ready_pulse: got %b expected 0", ra); end
        acc(1'b1, 1'b0, 32'h10, 32'h0, rd, e, lat, ra, rda);
        n_checks++; if (rd !== model[4] || e !== 1'b0) begin n_fail++; $display("FAIL err_word4_kept: got %h/%b expected %h/0", rd, e, model[4]); end
`ifdef UMEM_WRITE_MONITOR_EN
        n_checks++; if (mon_cnt !== mc) begin n_fail++; $display("FAIL err_mon_quiet: got %0d pulses expected 0", mon_cnt - mc); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, rda; logic e, ra; int lat;
        bit seen = 1'b0;
        acc(1'b1, 1'b1, 32'h20, 32'hA5A5_0001, rd, e, lat, ra, rda);
        model[8] = 32'hA5A5_0001; valid[8] = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h5A5A_0002;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; d_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; if (d_ready !== 1'b0 || err !== 1'b0) seen = 1'b1; end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (d_ready !== 1'b0 || err !== 1'b0) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_ready: got ready/err activity %b expected 0", seen); end
        acc(1'b1, 1'b0, 32'h20, 32'h0, rd, e, lat, ra, rda);
        n_checks++; if (rd !== model[8]) begin n_fail++; $display("FAIL rstmid_word8_kept: got %h expected %h", rd, model[8]); end
        n_checks++; if (lat !== WAIT_A + 1) begin n_fail++; $display("FAIL rstmid_idle_lat: got %0d expected %0d", lat, WAIT_A + 1); end
        acc(1'b1, 1'b1, 32'h20, 32'h5A5A_0002, rd, e, lat, ra, rda);
        model[8] = 32'h5A5A_0002;
        acc(1'b1, 1'b0, 32'h20, 32'h0, rd, e, lat, ra, rda);
        n_checks++; if (rd !== model[8] || e !== 1'b0) begin n_fail++; $display("FAIL rstmid_rerequest: got %h/%b expected %h/0", rd, e, model[8]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, rda; logic e, ra; int lat;
        int written[$];
        logic [31:0] a, wd;
        bit is_d, we, bad;
        int idx;
        for (int i = 0; i < 256; i++) if (valid[i]) written.push_back(i);
        for (int k = 0; k < 30; k++) begin
            bad = ($urandom_range(0, 9) < 2);
            we  = ($urandom_range(0, 2) == 0);
            is_d = we ? 1'b1 : ($urandom_range(0, 1) == 1);
            if (we) idx = $urandom_range(0, 255);
            else    idx = written[$urandom_range(0, written.size() - 1)];
            a = 32'(idx) * 4;
            if (bad) begin
                if ($urandom_range(0, 1) == 1) a = a + 32'($urandom_range(1, 3));
                else                           a = a + 32'h400 * 32'($urandom_range(1, 1000));
            end
            wd = $urandom;
            acc(is_d, we, a, wd, rd, e, lat, ra, rda);
            n_checks++; if (lat !== WAIT_A + 1) begin n_fail++; $display("FAIL rand_lat: op %0d got %0d expected %0d", k, lat, WAIT_A + 1); end
            n_checks++; if (e !== exp_err(a)) begin n_fail++; $display("FAIL rand_err: op %0d addr %h got %b expected %b", k, a, e, exp_err(a)); end
            if (we) begin
                if (!exp_err(a)) begin
                    model[a / 4] = wd;
                    if (!valid[a / 4]) begin valid[a / 4] = 1'b1; written.push_back(int'(a / 4)); end
                end
            end else begin
                n_checks++;
                if (rd !== (exp_err(a) ? 32'h0 : model[a / 4])) begin
                    n_fail++; $display("FAIL rand_rdata: op %0d addr %h got %h expected %h", k, a, rd, exp_err(a) ? 32'h0 : model[a / 4]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit          op_we [8];
        logic [31:0] op_a  [8];
        logic [31:0] op_wd [8];
        int base = $urandom_range(0, 255);
        int gap;
        for (int k = 0; k < 4; k++) begin
            op_we[k] = 1'b1; op_a[k] = 32'((base + k * 37) % 256) * 4; op_wd[k] = $urandom;
            op_we[k+4] = 1'b0; op_a[k+4] = op_a[k]; op_wd[k+4] = 32'h0;
        end
        @(negedge clk);
        d_req0 = 1'b1; d_we0 = op_we[0]; d_addr0 = op_a[0]; d_wdata0 = op_wd[0];
        for (int k = 0; k < 8; k++) begin
            gap = -1;
            for (int c = 1; c <= 6; c++) begin
                @(posedge clk); #1;
                if (d_ready0 === 1'b1) begin gap = c; break; end
            end
            n_checks++;
            if (gap !== ((k == 0) ? 1 : 2)) begin n_fail++; $display("FAIL b2b_gap: op %0d got %0d expected %0d", k, gap, (k == 0) ? 1 : 2); end
            if (op_we[k]) model0[op_a[k] / 4] = op_wd[k];
            else begin
                n_checks++;
                if (d_rdata0 !== model0[op_a[k] / 4]) begin n_fail++; $display("FAIL b2b_data: op %0d got %h expected %h", k, d_rdata0, model0[op_a[k] / 4]); end
            end
            @(negedge clk);
            if (k < 7) begin d_we0 = op_we[k+1]; d_addr0 = op_a[k+1]; d_wdata0 = op_wd[k+1]; end
            else d_req0 = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin valid[i] = 1'b0; model[i] = '0; model0[i] = '0; end
        test_reset();
        test_fetch();
        test_store_load();
        test_arbitration();
        test_errors();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
